// File: rtl/lif_neuron_driver_if.sv
// Handshake and neuron-pin bundle between the host, the LIF driver and the neuron.
// The slave modport is the driver's view; the master modport is the host/neuron side.
interface lif_neuron_driver_if #(
    parameter int N_STAGES = 4,
    parameter int RUN_BITS = 8
);
    localparam int INPUTS = 2 ** N_STAGES;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_load_weights;
    logic [INPUTS-1:0]   cmd_weights;
    logic [INPUTS-1:0]   cmd_inputs;
    logic [RUN_BITS-1:0] cmd_run_cycles;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [RUN_BITS-1:0] rsp_spikes;
    logic [RUN_BITS-1:0] rsp_first_spike;

    logic [7:0]          nrn_data;
    logic                nrn_sel_weights;
    logic                nrn_run;
    logic                nrn_spike;

    modport slave (
        input  cmd_valid, cmd_load_weights, cmd_weights, cmd_inputs, cmd_run_cycles,
        input  rsp_ready, nrn_spike,
        output cmd_ready, rsp_valid, rsp_spikes, rsp_first_spike,
        output nrn_data, nrn_sel_weights, nrn_run
    );

    modport master (
        output cmd_valid, cmd_load_weights, cmd_weights, cmd_inputs, cmd_run_cycles,
        output rsp_ready, nrn_spike,
        input  cmd_ready, rsp_valid, rsp_spikes, rsp_first_spike,
        input  nrn_data, nrn_sel_weights, nrn_run
    );
endinterface

// File: rtl/lif_neuron_driver.sv
// Host-side transmitter for the LIF neuron byte-load bus: loads weights/inputs
// MSB byte first, runs the neuron for a commanded number of cycles, counts spikes.
module lif_neuron_driver #(
    parameter int N_STAGES = 4,
    parameter int RUN_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    lif_neuron_driver_if.slave    bus
);
    localparam int INPUTS = 2 ** N_STAGES;
    localparam int BYTES  = (INPUTS + 7) / 8;
    localparam int PAD_W  = BYTES * 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, RUN, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [INPUTS-1:0]   weights_q, weights_d;
    logic [INPUTS-1:0]   inputs_q, inputs_d;
    logic [RUN_BITS-1:0] run_len_q, run_len_d;
    logic [RUN_BITS-1:0] run_idx_q, run_idx_d;
    logic [RUN_BITS-1:0] spikes_q, spikes_d;
    logic [RUN_BITS-1:0] first_q, first_d;

    // Vectors narrower than a byte multiple are zero-padded at the top.
    logic [PAD_W-1:0] w_pad, i_pad;
    logic [7:0]       w_byte, i_byte;
    assign w_pad  = PAD_W'(weights_q);
    assign i_pad  = PAD_W'(inputs_q);
    assign w_byte = w_pad[int'(idx_q) * 8 +: 8];
    assign i_byte = i_pad[int'(idx_q) * 8 +: 8];

    assign bus.rsp_spikes      = spikes_q;
    assign bus.rsp_first_spike = first_q;

    // Neuron pins and handshake flags decoded purely from registered state.
    always_comb begin
        // NOTE: every output gets a default first so no case arm can infer a latch.
        bus.cmd_ready       = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.nrn_data        = 8'h00;
        bus.nrn_sel_weights = 1'b0;
        bus.nrn_run         = 1'b0;
        case (state_q)
            IDLE:   bus.cmd_ready = 1'b1;
            LOAD_W: begin
                bus.nrn_sel_weights = 1'b1;
                bus.nrn_data        = w_byte;
            end
            LOAD_I: bus.nrn_data = i_byte;
            RUN:    bus.nrn_run = 1'b1;
            RESP:   bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Next-state, byte sequencing and spike accounting.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        weights_d = weights_q;
        inputs_d  = inputs_q;
        run_len_d = run_len_q;
        run_idx_d = run_idx_q;
        spikes_d  = spikes_q;
        first_d   = first_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                weights_d = bus.cmd_weights;
                inputs_d  = bus.cmd_inputs;
                run_len_d = bus.cmd_run_cycles;
                run_idx_d = '0;
                spikes_d  = '0;
                first_d   = '1;
                idx_d     = IDX_LAST;
                state_d   = bus.cmd_load_weights ? LOAD_W : LOAD_I;
            end
            LOAD_W: begin
                if (idx_q == '0) begin
                    idx_d   = IDX_LAST;
                    state_d = LOAD_I;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            LOAD_I: begin
                if (idx_q == '0) state_d = (run_len_q != '0) ? RUN : RESP;
                else             idx_d   = idx_q - IDX_W'(1);
            end
            RUN: begin
                if (bus.nrn_spike) begin
                    spikes_d = spikes_q + RUN_BITS'(1);
                    // All-ones never occurs as a run index, so it doubles as "no spike yet".
                    if (first_q == '1) first_d = run_idx_q;
                end
                if (run_idx_q == run_len_q - RUN_BITS'(1)) state_d = RESP;
                else run_idx_d = run_idx_q + RUN_BITS'(1);
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; command fields reset too for clean idle values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            weights_q <= '0;
            inputs_q  <= '0;
            run_len_q <= '0;
            run_idx_q <= '0;
            spikes_q  <= '0;
            first_q   <= '1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            weights_q <= weights_d;
            inputs_q  <= inputs_d;
            run_len_q <= run_len_d;
            run_idx_q <= run_idx_d;
            spikes_q  <= spikes_d;
            first_q   <= first_d;
        end
    end
endmodule

// File: tb/tb_lif_neuron_driver.sv
// Directed bench for lif_neuron_driver: scoreboard of expected bus beats and responses,
// plus a small behavioural LIF neuron for the closed-loop case.
module tb_lif_neuron_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lif_neuron_driver_if bus ();
    lif_neuron_driver dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [7:0] spikes; logic [7:0] first; } rsp_t;
    logic [9:0] beat_q[$];   // {nrn_run, nrn_sel_weights, nrn_data}
    rsp_t       rsp_q[$];

    logic tb_spike = 1'b0;
    bit   closed_loop = 1'b0;

    // Behavioural neuron: +1/-1 per active input, leak of m/4, threshold 40, reset to 0 on spike.
    logic [15:0] w_sr, i_sr;
    int          mem, pot;
    logic        model_spike;

    function automatic int nrn_sum(input logic [15:0] w, input logic [15:0] i);
        int s = 0;
        for (int b = 0; b < 16; b++) if (i[b]) s += w[b] ? 1 : -1;
        return s;
    endfunction

    always_comb begin
        pot         = mem - (mem >>> 2) + nrn_sum(w_sr, i_sr);
        model_spike = bus.nrn_run && (pot >= 40);
    end

    always @(posedge clk) begin
        if (reset) begin
            mem <= 0; w_sr <= '0; i_sr <= '0;
        end else if (!bus.nrn_run) begin
            if (bus.nrn_sel_weights) w_sr <= {w_sr[7:0], bus.nrn_data};
            else                     i_sr <= {i_sr[7:0], bus.nrn_data};
        end else begin
            mem <= (pot >= 40) ? 0 : pot;
        end
    end

    assign bus.nrn_spike = closed_loop ? model_spike : tb_spike;

    function automatic rsp_t golden(input logic [15:0] w, input logic [15:0] i, input int r);
        rsp_t res = '{spikes: 8'd0, first: 8'hFF};
        int m = 0;
        int p;
        for (int k = 0; k < r; k++) begin
            p = m - (m >>> 2) + nrn_sum(w, i);
            if (p >= 40) begin
                res.spikes++;
                if (res.first == 8'hFF) res.first = 8'(k);
                m = 0;
            end else m = p;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from an IDLE negedge; optionally stall the response or abort mid-run.
    task automatic do_cmd(input bit lw, input logic [15:0] w, input logic [15:0] i,
                          input logic [7:0] r, input logic [255:0] pat,
                          input int stall, input int abort_at);
        int   cyc = 0;
        int   ridx = 0;
        int   lat = (lw ? 2 : 0) + 2 + int'(r) + 1;
        rsp_t exp_rsp = '{spikes: 8'd0, first: 8'hFF};
        rsp_t got;
        logic [9:0] eb;
        if (lw) begin
            beat_q.push_back({2'b01, w[15:8]});
            beat_q.push_back({2'b01, w[7:0]});
        end
        beat_q.push_back({2'b00, i[15:8]});
        beat_q.push_back({2'b00, i[7:0]});
        for (int k = 0; k < int'(r); k++) begin
            beat_q.push_back(10'h200);
            if (!closed_loop && pat[k]) begin
                exp_rsp.spikes++;
                if (exp_rsp.first == 8'hFF) exp_rsp.first = 8'(k);
            end
        end
        if (closed_loop) exp_rsp = golden(w, i, int'(r));
        rsp_q.push_back(exp_rsp);

        bus.cmd_load_weights = lw;
        bus.cmd_weights      = w;
        bus.cmd_inputs       = i;
        bus.cmd_run_cycles   = r;
        bus.cmd_valid        = 1'b1;
        bus.rsp_ready        = (stall == 0);
        tb_spike             = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.cmd_valid = 1'b0;
            if (bus.rsp_valid === 1'b1) break;
            if (cyc > 600) begin
                check("timeout", 32'(cyc), 32'(lat));
                beat_q.delete(); rsp_q.delete();
                return;
            end
            eb = (beat_q.size() != 0) ? beat_q.pop_front() : 10'h3FF;
            check("bus", {22'd0, bus.nrn_run, bus.nrn_sel_weights, bus.nrn_data}, {22'd0, eb});
            if (bus.nrn_run === 1'b1) begin
                tb_spike = pat[ridx];
                ridx++;
            end else tb_spike = 1'b0;
            if (abort_at != 0 && cyc == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("abort_nrn_run", 32'(bus.nrn_run), 32'd0);
                check("abort_first", 32'(bus.rsp_first_spike), 32'hFF);
                reset = 1'b0;
                tb_spike = 1'b0;
                beat_q.delete(); rsp_q.delete();
                repeat (30) begin
                    @(negedge clk);
                    if (bus.rsp_valid !== 1'b0) break;
                end
                check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
                return;
            end
        end
        tb_spike = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        check("beats_left", 32'(beat_q.size()), 32'd0);
        beat_q.delete();
        got = {bus.rsp_spikes, bus.rsp_first_spike};
        exp_rsp = rsp_q.pop_front();
        check("rsp_spikes", 32'(got.spikes), 32'(exp_rsp.spikes));
        check("rsp_first", 32'(got.first), 32'(exp_rsp.first));
        for (int s = 0; s < stall; s++) begin
            bus.cmd_valid      = s[0];
            bus.cmd_run_cycles = 8'd77;
            @(negedge clk);
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_ready", 32'(bus.cmd_ready), 32'd0);
            check("stall_rsp", {16'd0, bus.rsp_spikes, bus.rsp_first_spike},
                  {16'd0, exp_rsp.spikes, exp_rsp.first});
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("back_idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("back_idle_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_load_weights = 1'b0;
        bus.cmd_weights = '0;
        bus.cmd_inputs = '0;
        bus.cmd_run_cycles = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_nrn_run", 32'(bus.nrn_run), 32'd0);
        check("rst_nrn_data", 32'(bus.nrn_data), 32'd0);
        check("rst_sel", 32'(bus.nrn_sel_weights), 32'd0);
        check("rst_spikes", 32'(bus.rsp_spikes), 32'd0);
        check("rst_first", 32'(bus.rsp_first_spike), 32'hFF);

        // Weights + inputs, zero-length run.
        do_cmd(1'b1, 16'hA5C3, 16'h1234, 8'd0, 256'd0, 0, 0);
        // Inputs only, four run cycles with spikes on r=1,2.
        do_cmd(1'b0, 16'h0000, 16'h00FF, 8'd4, 256'b0110, 0, 0);

        // Closed loop with the behavioural neuron from a fresh reset.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        closed_loop = 1'b1;
        do_cmd(1'b1, 16'hFFFF, 16'hFFFF, 8'd8, 256'd0, 0, 0);
        closed_loop = 1'b0;

        // Response held for three cycles with ignored command pulses.
        do_cmd(1'b0, 16'h0000, 16'h0F0F, 8'd3, 256'b101, 3, 0);
        // Maximum run length with spike tied high.
        do_cmd(1'b0, 16'h0000, 16'h00AA, 8'd255, {256{1'b1}}, 0, 0);
        // Reset in the middle of a run.
        do_cmd(1'b0, 16'h0000, 16'h5555, 8'd20, {256{1'b1}}, 0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
